// File: rtl/hex7seg_scan.sv
// hex7seg_scan: multiplexed N-digit hex 7-segment scanner with shadow/display double buffer.
// Latency: outputs registered one cycle behind pc/idx/display; no backpressure, load is always accepted.
module hex7seg_scan #(
    parameter int N_DIGITS = 4,
    parameter int DIV      = 50000,
    parameter int BLANK    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  blank_lz,
    input  logic                  enable,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   sel,
    output logic                  frame
);

    localparam int PW = $clog2(DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int VW = 4 * N_DIGITS;

    logic [PW-1:0]       pc_q, pc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [VW-1:0]       sh_val_q, sh_val_d, ds_val_q, ds_val_d;
    logic [N_DIGITS-1:0] sh_dp_q, sh_dp_d, ds_dp_q, ds_dp_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [N_DIGITS-1:0] sel_q, sel_d;
    logic                frame_q, frame_d;

    logic                tick, last_idx, scan_end;
    logic                lit, suppress, run_zero;
    logic [3:0]          nib;
    logic [N_DIGITS-1:0] zero_hi;

    function automatic logic [6:0] hex_code(input logic [3:0] n);
        logic [6:0] c;
        case (n)
            4'h0: c = 7'h40;  4'h1: c = 7'h79;  4'h2: c = 7'h24;  4'h3: c = 7'h30;
            4'h4: c = 7'h19;  4'h5: c = 7'h12;  4'h6: c = 7'h02;  4'h7: c = 7'h78;
            4'h8: c = 7'h00;  4'h9: c = 7'h10;  4'hA: c = 7'h08;  4'hB: c = 7'h03;
            4'hC: c = 7'h46;  4'hD: c = 7'h21;  4'hE: c = 7'h06;  default: c = 7'h0E;
        endcase
        return c;
    endfunction

    always_comb begin
        tick     = (pc_q == PW'(DIV - 1));
        last_idx = (idx_q == IW'(N_DIGITS - 1));
        scan_end = tick && last_idx;
        pc_d     = tick ? '0 : pc_q + 1'b1;
        idx_d    = idx_q;
        if (tick) idx_d = last_idx ? '0 : idx_q + 1'b1;
        sh_val_d = load ? value : sh_val_q;
        sh_dp_d  = load ? dp_in : sh_dp_q;
        // sh_*_d already carries a coincident load, so the display takes it directly
        ds_val_d = scan_end ? sh_val_d : ds_val_q;
        ds_dp_d  = scan_end ? sh_dp_d  : ds_dp_q;
        frame_d  = scan_end;
    end

    always_comb begin
        zero_hi  = '0;
        run_zero = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            run_zero   = run_zero & (ds_val_q[4*i +: 4] == 4'h0);
            zero_hi[i] = run_zero;
        end
        nib      = ds_val_q[4*idx_q +: 4];
        lit      = enable && (pc_q >= PW'(BLANK));
        suppress = blank_lz && (idx_q != '0) && zero_hi[idx_q];
        sel_d    = '1;
        seg_d    = 7'h7F;
        dp_d     = 1'b1;
        if (lit) begin
            sel_d[idx_q] = 1'b0;
            seg_d        = suppress ? 7'h7F : hex_code(nib);
            dp_d         = ~ds_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= '0;
            idx_q    <= '0;
            sh_val_q <= '0;
            sh_dp_q  <= '0;
            ds_val_q <= '0;
            ds_dp_q  <= '0;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
            sel_q    <= '1;
            frame_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            idx_q    <= idx_d;
            sh_val_q <= sh_val_d;
            sh_dp_q  <= sh_dp_d;
            ds_val_q <= ds_val_d;
            ds_dp_q  <= ds_dp_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            sel_q    <= sel_d;
            frame_q  <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign dp    = dp_q;
    assign sel   = sel_q;
    assign frame = frame_q;

endmodule
